// File: rtl/flow_gradient_if.sv
// Pixel stream in / gradient stream out bundle for the flow gradient stage.
// The slave side belongs to the gradient stage; the master side is its environment.
interface flow_gradient_if #(
    parameter int unsigned DATA_WIDTH  = 8,
    parameter int unsigned LINE_WIDTH  = 16,
    parameter int unsigned FRAME_LINES = 16
);
    localparam int unsigned XW = $clog2(LINE_WIDTH);
    localparam int unsigned YW = $clog2(FRAME_LINES);
    localparam int unsigned GW = DATA_WIDTH + 1;

    logic                  pix_valid;
    logic [DATA_WIDTH-1:0] pix_cur;
    logic [DATA_WIDTH-1:0] pix_prev;

    logic                  out_valid;
    logic [GW-1:0]         ix;
    logic [GW-1:0]         iy;
    logic [GW-1:0]         it;
    logic [XW-1:0]         out_x;
    logic [YW-1:0]         out_y;
    logic                  out_eol;
    logic                  out_eof;

    modport master (
        output pix_valid, pix_cur, pix_prev,
        input  out_valid, ix, iy, it, out_x, out_y, out_eol, out_eof
    );

    modport slave (
        input  pix_valid, pix_cur, pix_prev,
        output out_valid, ix, iy, it, out_x, out_y, out_eol, out_eof
    );
endinterface

// File: rtl/flow_gradient.sv
// Streaming Ix/Iy/It gradient stage: a raster pixel stream plus the co-located previous-frame
// pixel in, a signed gradient triplet tagged with coordinates and line/frame markers out.
module flow_gradient #(
    parameter int unsigned DATA_WIDTH  = 8,
    parameter int unsigned LINE_WIDTH  = 16,
    parameter int unsigned FRAME_LINES = 16
) (
    input  logic           clk,
    input  logic           rst,
    flow_gradient_if.slave bus
);
    localparam int unsigned XW = $clog2(LINE_WIDTH);
    localparam int unsigned YW = $clog2(FRAME_LINES);
    localparam int unsigned GW = DATA_WIDTH + 1;
    localparam logic [XW-1:0] X_LAST = XW'(LINE_WIDTH - 1);
    localparam logic [YW-1:0] Y_LAST = YW'(FRAME_LINES - 1);

    logic [XW-1:0]         x_q, x_d;
    logic [YW-1:0]         y_q, y_d;
    logic                  first_q, first_d;
    logic [DATA_WIDTH-1:0] left_q;
    logic [DATA_WIDTH-1:0] line_mem [LINE_WIDTH];
    logic [DATA_WIDTH-1:0] above;

    logic                  s1_valid_q;
    logic [DATA_WIDTH-1:0] s1_cur_q, s1_left_q, s1_above_q, s1_prev_q;
    logic [XW-1:0]         s1_x_q;
    logic [YW-1:0]         s1_y_q;
    logic                  s1_x0_q, s1_y0_q, s1_first_q;

    logic                  out_valid_q;
    logic [GW-1:0]         ix_q, iy_q, it_q;
    logic [XW-1:0]         out_x_q;
    logic [YW-1:0]         out_y_q;
    logic                  out_eol_q, out_eof_q;

    // Raster position and first-frame tracking; the flag drops once a full frame has been seen.
    always_comb begin
        x_d     = x_q;
        y_d     = y_q;
        first_d = first_q;
        if (bus.pix_valid) begin
            if (x_q == X_LAST) begin
                x_d = '0;
                if (y_q == Y_LAST) begin
                    y_d     = '0;
                    first_d = 1'b0;
                end else begin
                    y_d = y_q + 1'b1;
                end
            end else begin
                x_d = x_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            x_q     <= '0;
            y_q     <= '0;
            first_q <= 1'b1;
            left_q  <= '0;
        end else begin
            x_q     <= x_d;
            y_q     <= y_d;
            first_q <= first_d;
            if (bus.pix_valid) begin
                left_q <= bus.pix_cur;
            end
        end
    end

    // Line buffer is left unreset: row 0 never uses it, and the read sees the pre-write value.
    assign above = line_mem[x_q];

    always_ff @(posedge clk) begin
        if (bus.pix_valid) begin
            line_mem[x_q] <= bus.pix_cur;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid_q <= 1'b0;
            s1_cur_q   <= '0;
            s1_left_q  <= '0;
            s1_above_q <= '0;
            s1_prev_q  <= '0;
            s1_x_q     <= '0;
            s1_y_q     <= '0;
            s1_x0_q    <= 1'b0;
            s1_y0_q    <= 1'b0;
            s1_first_q <= 1'b0;
        end else begin
            s1_valid_q <= bus.pix_valid;
            if (bus.pix_valid) begin
                s1_cur_q   <= bus.pix_cur;
                s1_left_q  <= left_q;
                s1_above_q <= above;
                s1_prev_q  <= bus.pix_prev;
                s1_x_q     <= x_q;
                s1_y_q     <= y_q;
                s1_x0_q    <= (x_q == '0);
                s1_y0_q    <= (y_q == '0);
                s1_first_q <= first_q;
            end
        end
    end

    // Zero-extended subtraction covers -(2^DW-1)..+(2^DW-1) exactly in GW bits.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid_q <= 1'b0;
            ix_q        <= '0;
            iy_q        <= '0;
            it_q        <= '0;
            out_x_q     <= '0;
            out_y_q     <= '0;
            out_eol_q   <= 1'b0;
            out_eof_q   <= 1'b0;
        end else begin
            out_valid_q <= s1_valid_q;
            if (s1_valid_q) begin
                ix_q      <= s1_x0_q    ? '0 : ({1'b0, s1_cur_q} - {1'b0, s1_left_q});
                iy_q      <= s1_y0_q    ? '0 : ({1'b0, s1_cur_q} - {1'b0, s1_above_q});
                it_q      <= s1_first_q ? '0 : ({1'b0, s1_cur_q} - {1'b0, s1_prev_q});
                out_x_q   <= s1_x_q;
                out_y_q   <= s1_y_q;
                out_eol_q <= (s1_x_q == X_LAST);
                out_eof_q <= (s1_x_q == X_LAST) && (s1_y_q == Y_LAST);
            end
        end
    end

    assign bus.out_valid = out_valid_q;
    assign bus.ix        = ix_q;
    assign bus.iy        = iy_q;
    assign bus.it        = it_q;
    assign bus.out_x     = out_x_q;
    assign bus.out_y     = out_y_q;
    assign bus.out_eol   = out_eol_q;
    assign bus.out_eof   = out_eof_q;
endmodule

// File: tb/tb_flow_gradient.sv
// Directed bench for flow_gradient on a 4x2 frame: first frame, steady frame, extremes,
// input bubbles and mid-frame reset, each against hand-computed gradient vectors.
module tb_flow_gradient;
    logic clk;
    logic rst;
    int   pass_cnt;
    int   total_cnt;

    flow_gradient_if #(.DATA_WIDTH(8), .LINE_WIDTH(4), .FRAME_LINES(2)) bus ();

    flow_gradient #(.DATA_WIDTH(8), .LINE_WIDTH(4), .FRAME_LINES(2)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // {valid, ix, iy, it, x, y, eol, eof}
    logic [32:0] act;
    logic [32:0] exp_v;
    assign act = {bus.out_valid, bus.ix, bus.iy, bus.it, bus.out_x, bus.out_y, bus.out_eol, bus.out_eof};

    int ff_cur [8] = '{10, 20, 30, 40, 50, 60, 70, 80};
    int ff_ix  [8] = '{0, 10, 10, 10, 0, 10, 10, 10};
    int ff_iy  [8] = '{0, 0, 0, 0, 40, 40, 40, 40};
    int ex_cur [8] = '{255, 0, 255, 0, 0, 255, 255, 0};
    int ex_prv [8] = '{0, 0, 255, 255, 0, 0, 255, 0};
    int ex_ix  [8] = '{0, -255, 255, -255, 0, 255, 0, -255};
    int ex_iy  [8] = '{0, 0, 0, 0, -255, 255, 0, 0};
    int ex_it  [8] = '{255, 0, 0, -255, 0, 255, 0, 0};

    task automatic drive(input logic v, input int cur, input int prev);
        bus.pix_valid = v;
        bus.pix_cur   = 8'(cur);
        bus.pix_prev  = 8'(prev);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        drive(1'b0, 0, 0);
        #12;
        total_cnt++;
        if (act !== 33'd0) $display("FAIL reset_outputs: got %h want %h", act, 33'd0);
        else pass_cnt++;
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_first_frame();
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (i == 1) begin
                total_cnt++;
                if (bus.out_valid !== 1'b0) $display("FAIL ff_latency: out_valid %b want 0", bus.out_valid);
                else pass_cnt++;
            end
            if (i >= 2) begin
                int k;
                k = i - 2;
                exp_v = {1'b1, 9'(ff_ix[k]), 9'(ff_iy[k]), 9'd0, 2'(k % 4), 1'(k / 4), (k % 4 == 3), (k == 7)};
                total_cnt++;
                if (act !== exp_v) $display("FAIL ff_pix%0d: got %h want %h", k, act, exp_v);
                else pass_cnt++;
            end
            if (i < 8) drive(1'b1, ff_cur[i], 99);
            else       drive(1'b0, 0, 0);
        end
        @(negedge clk);
        total_cnt++;
        if (bus.out_valid !== 1'b0) $display("FAIL ff_single_pulse: out_valid %b want 0", bus.out_valid);
        else pass_cnt++;
    endtask

    task automatic test_second_frame();
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (i >= 2) begin
                int k;
                k = i - 2;
                exp_v = {1'b1, 9'd0, 9'd0, 9'h1FB, 2'(k % 4), 1'(k / 4), (k % 4 == 3), (k == 7)};
                total_cnt++;
                if (act !== exp_v) $display("FAIL sf_pix%0d: got %h want %h", k, act, exp_v);
                else pass_cnt++;
            end
            if (i < 8) drive(1'b1, 5, 10);
            else       drive(1'b0, 0, 0);
        end
    endtask

    task automatic test_extremes();
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (i >= 2) begin
                int k;
                k = i - 2;
                exp_v = {1'b1, 9'(ex_ix[k]), 9'(ex_iy[k]), 9'(ex_it[k]), 2'(k % 4), 1'(k / 4), (k % 4 == 3), (k == 7)};
                total_cnt++;
                if (act !== exp_v) $display("FAIL ex_pix%0d: got %h want %h", k, act, exp_v);
                else pass_cnt++;
            end
            if (i < 8) drive(1'b1, ex_cur[i], ex_prv[i]);
            else       drive(1'b0, 0, 0);
        end
    endtask

    task automatic test_bubbles();
        int          n_in;
        int          n_out;
        logic        pat [26];
        logic [8:0]  last_ix;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        n_in    = 0;
        n_out   = 0;
        last_ix = 9'd0;
        for (int i = 0; i < 26; i++) pat[i] = (i < 24) && (i % 3 == 0);
        for (int i = 0; i < 26; i++) begin
            @(negedge clk);
            if (i >= 2) begin
                if (pat[i-2]) begin
                    exp_v = {1'b1, 9'(ff_ix[n_out]), 9'(ff_iy[n_out]), 9'd0, 2'(n_out % 4), 1'(n_out / 4),
                             (n_out % 4 == 3), (n_out == 7)};
                    total_cnt++;
                    if (act !== exp_v) $display("FAIL bub_pix%0d: got %h want %h", n_out, act, exp_v);
                    else pass_cnt++;
                    last_ix = 9'(ff_ix[n_out]);
                    n_out++;
                end else begin
                    total_cnt++;
                    if ({bus.out_valid, bus.ix} !== {1'b0, last_ix})
                        $display("FAIL bub_idle%0d: got v=%b ix=%h want v=0 ix=%h", i, bus.out_valid, bus.ix, last_ix);
                    else pass_cnt++;
                end
            end
            if (pat[i]) begin
                drive(1'b1, ff_cur[n_in], 99);
                n_in++;
            end else begin
                drive(1'b0, 0, 0);
            end
        end
    endtask

    task automatic test_reset_mid_frame();
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            drive(1'b1, i + 1, 0);
        end
        @(negedge clk);
        drive(1'b0, 0, 0);
        #1 rst = 1'b1;
        #1;
        total_cnt++;
        if (act !== 33'd0) $display("FAIL rst_mid_outputs: got %h want %h", act, 33'd0);
        else pass_cnt++;
        @(negedge clk);
        rst = 1'b0;
        drive(1'b1, 7, 33);
        @(negedge clk);
        drive(1'b0, 0, 0);
        total_cnt++;
        if (bus.out_valid !== 1'b0) $display("FAIL rst_mid_flush: out_valid %b want 0", bus.out_valid);
        else pass_cnt++;
        @(negedge clk);
        exp_v = {1'b1, 9'd0, 9'd0, 9'd0, 2'd0, 1'd0, 1'b0, 1'b0};
        total_cnt++;
        if (act !== exp_v) $display("FAIL rst_mid_first_pix: got %h want %h", act, exp_v);
        else pass_cnt++;
        @(negedge clk);
        total_cnt++;
        if (bus.out_valid !== 1'b0) $display("FAIL rst_mid_pulse: out_valid %b want 0", bus.out_valid);
        else pass_cnt++;
    endtask

    initial begin
        pass_cnt  = 0;
        total_cnt = 0;
        test_reset();
        test_first_frame();
        test_second_frame();
        test_extremes();
        test_bubbles();
        test_reset_mid_frame();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end
endmodule

// File: doc/flow_gradient.md
# flow_gradient

Streaming gradient stage that sits directly downstream of the dual-port frame buffer in the flow-estimation pipeline. Each accepted pixel is paired with the previous-frame pixel at the same position, read from the frame buffer. The block computes the spatial gradients Ix and Iy and the temporal gradient It as signed differences. The registered gradient triplet, tagged with pixel coordinates and line/frame markers, feeds the flow solver.

## Interface

Parameters:
- DATA_WIDTH, 8, pixel width in bits
- LINE_WIDTH, 16, pixels per line (>= 2)
- FRAME_LINES, 16, lines per frame (>= 2); LINE_WIDTH*FRAME_LINES equals the frame buffer depth

Ports:
- clk  in  1  single clock, rising edge
- rst  in  1  asynchronous, active-high reset
- pix_valid  in  1  pix_cur/pix_prev valid this cycle
- pix_cur  in  DATA_WIDTH  current-frame pixel, raster order
- pix_prev  in  DATA_WIDTH  previous-frame pixel at same position, from frame buffer read port, aligned with pix_cur
- out_valid  out  1  gradient outputs valid
- ix  out  DATA_WIDTH+1  signed, cur − left neighbour
- iy  out  DATA_WIDTH+1  signed, cur − pixel above
- it  out  DATA_WIDTH+1  signed, cur − previous-frame pixel
- out_x  out  clog2(LINE_WIDTH)  column of output pixel
- out_y  out  clog2(FRAME_LINES)  line of output pixel
- out_eol  out  1  output pixel is last in line
- out_eof  out  1  output pixel is last in frame

## Operation

- Counters x, y advance only on pix_valid. x wraps LINE_WIDTH−1 → 0 and increments y; y wraps FRAME_LINES−1 → 0 at end of frame.
- first_frame flag: set by reset, cleared when the last pixel of a frame (x=LINE_WIDTH−1, y=FRAME_LINES−1) is accepted.
- Left register: holds the previously accepted pixel; loaded on every pix_valid.
- Line buffer: LINE_WIDTH entries × DATA_WIDTH. At each accepted pixel, entry[x] is read (old content) and then overwritten with pix_cur in the same cycle. Read-during-write returns the old value.
- Stage 1 (registered): captures cur, left, above, prev, x, y, and the boundary flags x==0, y==0, first_frame.
- Stage 2 (registered): computes the differences. All operands are zero-extended to DATA_WIDTH+1 and subtracted in two's complement. The full range −(2^DW−1)..+(2^DW−1) is exact, with no saturation.
- Boundary rules:
  - x==0 → ix=0 (no wrap across lines).
  - y==0 → iy=0.
  - first_frame → it=0; pix_prev is ignored because the frame buffer holds no valid data yet.
- out_eol = (out_x==LINE_WIDTH−1). out_eof = out_eol and (out_y==FRAME_LINES−1).
- No backpressure; the consumer must accept every out_valid cycle.

## Timing

- Latency: a pixel accepted at edge N appears at outputs after edge N+2, with out_valid=1 for exactly one cycle.
- Throughput: one pixel per clock. Idle input cycles produce out_valid=0 bubbles two cycles later and leave counters, left register and line buffer unchanged.
- While out_valid=0, ix/iy/it/out_x/out_y/out_eol/out_eof hold their last values.
- Reset, asynchronous, effective immediately:
  - Outputs: out_valid, ix, iy, it, out_x, out_y, out_eol, out_eof all go to 0.
  - Counters: x and y go to 0.
  - Flags and registers: first_frame=1, the pipeline valid bits clear, and the left register clears.
  - Line buffer contents need no reset, because the y==0 rule masks them.
- Reset mid-frame: in-flight pixels are discarded. The next accepted pixel is (0,0) of a first frame.
- Deassertion: the first pixel can be accepted on the first rising edge after rst falls.

## Test plan

Use LINE_WIDTH=4, FRAME_LINES=2 for all scenarios.

- **First frame.** Reset, then 8 consecutive pixels cur=10,20,30,40,50,60,70,80 with prev=99.
  - Outputs two cycles later: ix=0,10,10,10,0,10,10,10; iy=0,0,0,0,40,40,40,40; it=0 for all.
  - out_eol on pixels 3 and 7; out_eof on pixel 7 only.
- **Second frame.** Continue with cur=5 for all 8 pixels and prev=10 for all 8 pixels.
  - it=−5 (9'h1FB) for every pixel.
  - ix=0 for every pixel.
  - iy: row 0 gives 0; row 1 gives 5−5=0.
  - out_x/out_y sequence (0,0)…(3,1).
- **Extremes (second frame).**
  - cur=0 after left=255 → ix=−255 (9'h101).
  - cur=255 with prev=0 → it=+255 (9'h0FF).
  - No overflow or saturation.
- **Bubbles.** Drive the first-frame sequence with pix_valid toggling 1,0,0,1,…
  - Output values are identical to scenario 1.
  - out_valid mirrors the input valid pattern, delayed 2 cycles.
- **Reset mid-frame.** Assert rst after 3 pixels of the second frame.
  - All outputs read 0 immediately.
  - Next pixel cur=7: out_x=0, out_y=0, ix=iy=it=0, out_valid two cycles later.
